// File: rtl/map_tiles_if.sv
// map_tiles_if: layout-load and damage handshakes between game logic and the tile map.
//   load_start  master->slave  pulse, begin a layout load
//   load_valid  master->slave  load_data valid
//   load_data   master->slave  tile code (0 empty, 1 solid, 2 brick full hp, 3 brick hp=1)
//   load_ready  slave->master  beat accepted when valid & ready
//   dmg_valid   master->slave  damage request
//   dmg_x/y     master->slave  damage pixel coordinate
//   dmg_ready   slave->master  request accepted when valid & ready
//   dmg_done    slave->master  one-cycle pulse, cycle after accept
//   dmg_result  slave->master  0 none, 1 damaged, 2 destroyed, 3 indestructible
interface map_tiles_if #(
    parameter int unsigned CW = 8
);
    logic          load_start;
    logic          load_valid;
    logic [1:0]    load_data;
    logic          load_ready;
    logic          dmg_valid;
    logic [CW-1:0] dmg_x;
    logic [CW-1:0] dmg_y;
    logic          dmg_ready;
    logic          dmg_done;
    logic [1:0]    dmg_result;

    modport master (
        output load_start, load_valid, load_data, dmg_valid, dmg_x, dmg_y,
        input  load_ready, dmg_ready, dmg_done, dmg_result
    );

    modport slave (
        input  load_start, load_valid, load_data, dmg_valid, dmg_x, dmg_y,
        output load_ready, dmg_ready, dmg_done, dmg_result
    );
endinterface

// File: rtl/map_tiles.sv
// map_tiles: run-time writable tile grid (empty / solid / brick with hit points).
//   clk, rst          clock, synchronous active-high reset
//   rd_x/rd_y         render pixel; rd_wall/rd_brick registered, 1-cycle latency
//   q_x/q_y           NQ packed query pixels; q_wall registered (all ones while busy)
//   bus               load and damage handshakes (map_tiles_if.slave)
//   bricks_left       number of brick tiles with hp > 0
//   busy              high whenever not in READY
module map_tiles #(
    parameter int unsigned MAP_W   = 200,
    parameter int unsigned MAP_H   = 144,
    parameter int unsigned TILE_SH = 2,
    parameter int unsigned CW      = 8,
    parameter int unsigned NQ      = 4,
    parameter int unsigned HPW     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    rd_x,
    input  logic [CW-1:0]    rd_y,
    output logic             rd_wall,
    output logic             rd_brick,
    input  logic [NQ*CW-1:0] q_x,
    input  logic [NQ*CW-1:0] q_y,
    output logic [NQ-1:0]    q_wall,
    map_tiles_if.slave       bus,
    output logic [10:0]      bricks_left,
    output logic             busy
);
    localparam int unsigned TW = MAP_W >> TILE_SH;
    localparam int unsigned TH = MAP_H >> TILE_SH;
    localparam int unsigned NT = TW * TH;
    localparam int unsigned IW = $clog2(NT);
    localparam int unsigned XW = $clog2(TW);
    localparam int unsigned YW = $clog2(TH);
    localparam int unsigned BW = 11;
    localparam logic [HPW-1:0] HP_MAX = '1;
    localparam logic [HPW-1:0] HP_ONE = HPW'(1);

    typedef struct packed {
        logic           solid;
        logic [HPW-1:0] hp;
    } tile_t;

    typedef enum logic [1:0] {CLEAR, READY, LOAD} state_t;

    state_t        state, state_nxt;
    tile_t         grid [NT];
    logic [IW-1:0] idx;
    logic [XW-1:0] tx;
    logic [YW-1:0] ty;
    logic          cnt_adv;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    tile_t         wr_tile;
    logic [BW-1:0] bl_nxt;
    logic          dmg_acc;
    logic [1:0]    dmg_res_c;
    tile_t         rd_t, dmg_t;
    logic          rd_oob, dmg_oob;
    logic [IW-1:0] dmg_idx;
    logic [NQ-1:0] q_wall_c;

    function automatic logic is_oob(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return (32'(x) >= MAP_W) || (32'(y) >= MAP_H);
    endfunction

    // Off-map coordinates map to tile 0 so the array is never indexed out of range
    function automatic logic [IW-1:0] tile_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
        logic [31:0] i;
        if (is_oob(x, y)) return '0;
        i = 32'(y >> TILE_SH) * TW + 32'(x >> TILE_SH);
        return IW'(i);
    endfunction

    function automatic logic is_wall(input tile_t t);
        return t.solid || (t.hp != '0);
    endfunction

    function automatic logic is_brick(input tile_t t);
        return !t.solid && (t.hp != '0);
    endfunction

    // Read ports: render, damage lookup, NQ collision queries
    always_comb begin
        rd_oob   = is_oob(rd_x, rd_y);
        rd_t     = grid[tile_idx(rd_x, rd_y)];
        dmg_oob  = is_oob(bus.dmg_x, bus.dmg_y);
        dmg_idx  = tile_idx(bus.dmg_x, bus.dmg_y);
        dmg_t    = grid[dmg_idx];
        q_wall_c = '0;
        for (int k = 0; k < NQ; k++) begin
            q_wall_c[k] = is_oob(q_x[k*CW +: CW], q_y[k*CW +: CW]) ||
                          is_wall(grid[tile_idx(q_x[k*CW +: CW], q_y[k*CW +: CW])]);
        end
    end

    // Next state, handshakes and the single grid write port
    always_comb begin
        state_nxt      = state;
        busy           = 1'b1;
        bus.load_ready = 1'b0;
        bus.dmg_ready  = 1'b0;
        cnt_adv        = 1'b0;
        wr_en          = 1'b0;
        wr_idx         = idx;
        wr_tile        = '0;
        bl_nxt         = bricks_left;
        dmg_acc        = 1'b0;
        dmg_res_c      = 2'd0;
        case (state)
            CLEAR: begin
                wr_en         = 1'b1;
                wr_tile.solid = (tx == '0) || (tx == XW'(TW - 1)) ||
                                (ty == '0) || (ty == YW'(TH - 1));
                cnt_adv       = 1'b1;
                bl_nxt        = '0;
                if (idx == IW'(NT - 1)) state_nxt = READY;
            end
            READY: begin
                busy          = 1'b0;
                bus.dmg_ready = !bus.load_start;
                dmg_acc       = bus.dmg_valid && !bus.load_start;
                if (bus.load_start) begin
                    state_nxt = LOAD;
                    bl_nxt    = '0;
                end
                if (dmg_acc) begin
                    wr_idx = dmg_idx;
                    if (dmg_oob || dmg_t.solid) begin
                        dmg_res_c = 2'd3;
                    end else if (dmg_t.hp == HP_ONE) begin
                        dmg_res_c = 2'd2;
                        wr_en     = 1'b1;
                        bl_nxt    = bricks_left - BW'(1);
                    end else if (dmg_t.hp != '0) begin
                        dmg_res_c  = 2'd1;
                        wr_en      = 1'b1;
                        wr_tile.hp = dmg_t.hp - HP_ONE;
                    end
                end
            end
            LOAD: begin
                bus.load_ready = 1'b1;
                if (bus.load_valid) begin
                    wr_en   = 1'b1;
                    cnt_adv = 1'b1;
                    case (bus.load_data)
                        2'd1:    wr_tile.solid = 1'b1;
                        2'd2:    wr_tile.hp    = HP_MAX;
                        2'd3:    wr_tile.hp    = HP_ONE;
                        default: wr_tile       = '0;
                    endcase
                    if (bus.load_data[1]) bl_nxt = bricks_left + BW'(1);
                    if (idx == IW'(NT - 1)) state_nxt = READY;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_nxt;
    end

    // Raster counters; wrap to zero after the last tile so the next load starts at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            tx  <= '0;
            ty  <= '0;
        end else if (cnt_adv) begin
            if (idx == IW'(NT - 1)) begin
                idx <= '0;
                tx  <= '0;
                ty  <= '0;
            end else begin
                idx <= idx + IW'(1);
                if (tx == XW'(TW - 1)) begin
                    tx <= '0;
                    ty <= ty + YW'(1);
                end else begin
                    tx <= tx + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) grid[wr_idx] <= wr_tile;
    end

    // Registered read results, damage response and brick count
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_wall        <= 1'b0;
            rd_brick       <= 1'b0;
            q_wall         <= '0;
            bus.dmg_done   <= 1'b0;
            bus.dmg_result <= 2'd0;
            bricks_left    <= '0;
        end else begin
            rd_wall      <= rd_oob || is_wall(rd_t);
            rd_brick     <= !rd_oob && is_brick(rd_t);
            q_wall       <= busy ? '1 : q_wall_c;
            bus.dmg_done <= dmg_acc;
            if (dmg_acc) bus.dmg_result <= dmg_res_c;
            bricks_left  <= bl_nxt;
        end
    end
endmodule

// File: tb/tb_map_tiles.sv
// tb_map_tiles: directed checks of clear, load, damage, arbitration and reset abort.
module tb_map_tiles;
    localparam int unsigned CW = 8;
    localparam int unsigned NQ = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [CW-1:0]    rd_x, rd_y;
    logic             rd_wall, rd_brick;
    logic [NQ*CW-1:0] q_x, q_y;
    logic [NQ-1:0]    q_wall;
    logic [10:0]      bricks_left;
    logic             busy;
    int               n_tests = 0;
    int               n_fail  = 0;
    int               beat, cyc;
    logic             acc;

    map_tiles_if #(.CW(CW)) bus ();

    map_tiles #(
        .MAP_W(200), .MAP_H(144), .TILE_SH(2), .CW(CW), .NQ(NQ), .HPW(2)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_x(rd_x), .rd_y(rd_y), .rd_wall(rd_wall), .rd_brick(rd_brick),
        .q_x(q_x), .q_y(q_y), .q_wall(q_wall),
        .bus(bus),
        .bricks_left(bricks_left), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_q(input int k, input int x, input int y);
        q_x[k*CW +: CW] = CW'(x);
        q_y[k*CW +: CW] = CW'(y);
    endtask

    // Called on the first negedge after a reset edge; counts cycles until READY
    task automatic wait_clear(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n), 1800);
    endtask

    task automatic dmg_once(input string tag, input int x, input int y, input int exp);
        bus.dmg_valid = 1'b1;
        bus.dmg_x     = CW'(x);
        bus.dmg_y     = CW'(y);
        @(negedge clk);
        check({tag, "_done"}, 32'(bus.dmg_done), 1);
        check({tag, "_res"}, 32'(bus.dmg_result), 32'(exp));
        bus.dmg_valid = 1'b0;
        @(negedge clk);
        check({tag, "_single"}, 32'(bus.dmg_done), 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 2'd0;
        bus.dmg_valid  = 1'b0;
        bus.dmg_x      = '0;
        bus.dmg_y      = '0;
        rd_x           = CW'(5);
        rd_y           = CW'(9);
        q_x            = '0;
        q_y            = '0;
        set_q(0, 0, 0);
        set_q(1, 100, 72);
        set_q(2, 199, 143);
        set_q(3, 200, 10);

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_rd_wall", 32'(rd_wall), 0);
        check("rst_rd_brick", 32'(rd_brick), 0);
        check("rst_q_wall", 32'(q_wall), 0);
        check("rst_load_ready", 32'(bus.load_ready), 0);
        check("rst_dmg_ready", 32'(bus.dmg_ready), 0);
        check("rst_dmg_done", 32'(bus.dmg_done), 0);
        check("rst_dmg_result", 32'(bus.dmg_result), 0);
        check("rst_bricks", 32'(bricks_left), 0);
        check("rst_busy", 32'(busy), 1);
        rst = 1'b0;

        // Power-up clear: border solid, interior empty
        wait_clear("clear_len");
        check("qwall_last_busy", 32'(q_wall), 'hF);
        @(negedge clk);
        check("clear_qwall", 32'(q_wall), 'hD);
        check("clear_rd_wall", 32'(rd_wall), 0);
        check("clear_rd_brick", 32'(rd_brick), 0);
        check("ready_dmg_ready", 32'(bus.dmg_ready), 1);
        check("clear_bricks", 32'(bricks_left), 0);

        // Load: all empty except tile 101 = full brick, valid drops every 3rd cycle
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        check("load_busy", 32'(busy), 1);
        check("load_ready", 32'(bus.load_ready), 1);
        beat = 0;
        cyc  = 0;
        while (beat < 1800 && cyc < 4000) begin
            bus.load_valid = (cyc % 3 != 2);
            bus.load_data  = (beat == 101) ? 2'd2 : 2'd0;
            acc            = bus.load_valid && bus.load_ready;
            @(negedge clk);
            if (acc) beat++;
            cyc++;
            if (cyc == 10) check("load_qwall_busy", 32'(q_wall), 'hF);
        end
        bus.load_valid = 1'b0;
        check("load_beats", 32'(beat), 1800);
        check("load_cycles", 32'(cyc), 2699);
        check("load_done_busy", 32'(busy), 0);
        check("load_done_ready", 32'(bus.load_ready), 0);
        check("load_bricks", 32'(bricks_left), 1);
        check("load_rd_brick", 32'(rd_brick), 1);
        check("load_rd_wall", 32'(rd_wall), 1);
        @(negedge clk);
        check("load_qwall", 32'(q_wall), 'h8);

        // Three back-to-back hits on the brick at (5,9)
        set_q(1, 5, 9);
        bus.dmg_valid = 1'b1;
        bus.dmg_x     = CW'(5);
        bus.dmg_y     = CW'(9);
        check("dmg_ready", 32'(bus.dmg_ready), 1);
        @(negedge clk);
        check("hit1_done", 32'(bus.dmg_done), 1);
        check("hit1_res", 32'(bus.dmg_result), 1);
        check("hit1_bricks", 32'(bricks_left), 1);
        @(negedge clk);
        check("hit2_done", 32'(bus.dmg_done), 1);
        check("hit2_res", 32'(bus.dmg_result), 1);
        @(negedge clk);
        check("hit3_done", 32'(bus.dmg_done), 1);
        check("hit3_res", 32'(bus.dmg_result), 2);
        check("hit3_bricks", 32'(bricks_left), 0);
        check("hit3_qwall_old", 32'(q_wall[1]), 1);
        bus.dmg_valid = 1'b0;
        @(negedge clk);
        check("hit3_qwall_new", 32'(q_wall[1]), 0);
        check("hit3_rd_wall", 32'(rd_wall), 0);
        check("idle_dmg_done", 32'(bus.dmg_done), 0);

        // Damage on empty, off-map and the (now empty) loaded corner
        dmg_once("dmg_empty", 100, 72, 0);
        dmg_once("dmg_oob", 200, 10, 3);
        dmg_once("dmg_corner_loaded", 0, 0, 0);

        // load_start wins over a simultaneous damage request
        bus.load_start = 1'b1;
        bus.dmg_valid  = 1'b1;
        bus.dmg_x      = CW'(5);
        bus.dmg_y      = CW'(9);
        #1;
        check("arb_dmg_ready", 32'(bus.dmg_ready), 0);
        @(negedge clk);
        bus.load_start = 1'b0;
        bus.dmg_valid  = 1'b0;
        check("arb_dmg_done", 32'(bus.dmg_done), 0);
        check("arb_busy", 32'(busy), 1);
        check("arb_load_ready", 32'(bus.load_ready), 1);

        // 900 brick beats, then reset mid-load
        bus.load_valid = 1'b1;
        bus.load_data  = 2'd2;
        repeat (900) @(negedge clk);
        check("half_bricks", 32'(bricks_left), 900);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 1);
        check("abort_bricks", 32'(bricks_left), 0);
        check("abort_load_ready", 32'(bus.load_ready), 0);
        rst            = 1'b0;
        bus.load_valid = 1'b0;
        set_q(0, 0, 0);
        set_q(1, 5, 9);
        set_q(2, 100, 72);
        set_q(3, 199, 143);
        wait_clear("clear_after_abort");
        @(negedge clk);
        check("abort_qwall", 32'(q_wall), 'h9);
        check("abort_rd_wall", 32'(rd_wall), 0);
        check("abort_bricks_after", 32'(bricks_left), 0);
        dmg_once("dmg_solid", 0, 0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
